// File: rtl/register_dump.sv
// Debug register dumper: walks every bank address, reads each word and streams
// it out MSB-first as bytes over a valid/ready interface toward the debug UART.
module register_dump #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDRESS  = 5,
  parameter int N_REGISTERS = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic [NB_ADDRESS-1:0] o_r_addr,
  output logic                  o_r_en,
  input  logic [NB_DATA-1:0]    i_r_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int NBYTES = NB_DATA / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t                  state, state_nxt;
  logic [NB_ADDRESS-1:0]   addr, addr_nxt;
  logic [NB_DATA-1:0]      shreg, shreg_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    transfer;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      addr  <= '0;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign transfer = o_tx_valid & i_tx_ready;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = READ;
          addr_nxt  = '0;
        end
      end
      READ: begin
        shreg_nxt = i_r_data;
        cnt_nxt   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        if (transfer) begin
          if (cnt == CW'(NBYTES - 1)) begin
            // Stop on the last register so the address never wraps with a read.
            if (addr == NB_ADDRESS'(N_REGISTERS - 1)) begin
              state_nxt = DONE;
            end else begin
              addr_nxt  = addr + NB_ADDRESS'(1);
              state_nxt = READ;
            end
          end else begin
            shreg_nxt = shreg << 8;
            cnt_nxt   = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_r_addr   = addr;
  assign o_r_en     = (state == READ);
  assign o_tx_data  = shreg[NB_DATA-1 -: 8];
  assign o_tx_valid = (state == SEND);
  assign o_busy     = (state != IDLE);
  assign o_done     = (state == DONE);

endmodule

// File: tb/tb_register_dump.sv
// Scoreboard bench for register_dump: stimulus queues expected bytes, a negedge
// monitor pops and compares them on every transfer and checks protocol rules.
module tb_register_dump;
  localparam int NB_DATA = 32;
  localparam int NB_ADDRESS = 5;
  localparam int N_REGISTERS = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [NB_ADDRESS-1:0] r_addr;
  logic                  r_en;
  logic [NB_DATA-1:0]    r_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready = 1'b1;
  logic                  busy;
  logic                  done;

  logic [NB_DATA-1:0] bank [N_REGISTERS];
  assign r_data = bank[r_addr];

  register_dump #(.NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS), .N_REGISTERS(N_REGISTERS)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start),
    .o_r_addr(r_addr), .o_r_en(r_en), .i_r_data(r_data),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q [$];
  int  ready_mode = 0;     // 0: always ready, 1: random 30% duty
  int  s_edge = 0;
  int  exp_addr = 0;
  int  reads = 0;
  int  popped = 0;
  int  done_cnt = 0;
  bit  seen_valid = 0;
  bit  chk_timing = 0;
  bit  after_done = 0;
  bit  hold = 0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ready driver: updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 1) tx_ready = ($urandom_range(0, 9) < 3);
    else tx_ready = 1'b1;
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold = 0;
      after_done = 0;
    end else begin
      if (after_done) begin
        check("busy_after_done", busy, 0);
        after_done = 0;
      end
      if (hold) begin
        check("valid_stable", tx_valid, 1);
        check("data_stable", tx_data, hold_data);
      end
      if (start && !busy) begin
        s_edge = cyc + 1;
        exp_addr = 0;
        seen_valid = 0;
      end
      if (tx_valid && !seen_valid) begin
        seen_valid = 1;
        check("first_valid_latency", cyc - s_edge + 1, 2);
      end
      if (r_en) begin
        check("read_addr", r_addr, exp_addr);
        exp_addr++;
        reads++;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL extra_byte actual=%0h required=none", tx_data);
        end else begin
          check("byte", tx_data, exp_q.pop_front());
        end
        popped++;
      end
      if (done) begin
        done_cnt++;
        after_done = 1;
        if (chk_timing) check("done_latency", cyc - s_edge + 1, 161);
      end
      hold = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  task automatic queue_dump();
    for (int r = 0; r < N_REGISTERS; r++)
      for (int b = NB_DATA / 8 - 1; b >= 0; b--)
        exp_q.push_back(8'(bank[r] >> (8 * b)));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      errors++; checks++;
      $display("FAIL done_timeout actual=none required=pulse");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_dump(input string tag, input bit extra_starts, input int budget);
    done_cnt = 0; reads = 0; popped = 0;
    queue_dump();
    if (!extra_starts) pulse_start();
    else begin
      @(posedge clk); #1; start = 1'b1;   // accepted in IDLE
      @(posedge clk); #1; start = 1'b1;   // lands in READ
      @(posedge clk); #1; start = 1'b1;   // lands in SEND
      @(posedge clk); #1; start = 1'b0;
      repeat (7) @(posedge clk);
      #1; start = 1'b1;                   // a later READ/SEND
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done(budget);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_reads"}, reads, N_REGISTERS);
    check({tag, "_bytes"}, popped, N_REGISTERS * NB_DATA / 8);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_idle_busy"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    for (int k = 0; k < N_REGISTERS; k++) bank[k] = 32'h01010101 * k;
    #2;
    check("rst_addr", r_addr, 0);
    check("rst_ren", r_en, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full dump at full rate, with exact timing checks.
    chk_timing = 1;
    run_dump("full", 0, 400);
    chk_timing = 0;

    // Byte order: distinctive word in reg[0] and the last register.
    bank[0] = 32'hDEADBEEF;
    bank[31] = 32'h8C4A2E01;
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    for (int k = 0; k < 4; k++) begin
      check("order_table", exp_q[k], 8'(bank[0] >> (24 - 8 * k)));
    end
    exp_q.delete();
    run_dump("order", 0, 400);
    bank[0] = 32'h0;
    bank[31] = 32'h1F1F1F1F;

    // Backpressure at 30% ready duty.
    ready_mode = 1;
    run_dump("bp", 0, 3000);
    ready_mode = 0;

    // Start pulses while busy are ignored.
    run_dump("restart", 1, 400);

    // Asynchronous reset in the middle of reg[5].
    done_cnt = 0; popped = 0;
    queue_dump();
    pulse_start();
    for (int n = 0; n < 400 && popped < 22; n++) @(negedge clk);
    check("reached_reg5", popped, 22);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", r_addr, 0);
    check("mid_rst_ren", r_en, 0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt, 0);
    check("idle_after_abort", busy, 0);
    run_dump("post_rst", 0, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
